imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader that writes a checksummed image into instruction memory
module imem_loader #(
   parameter int          MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_imem_we,
   output logic [31:0] o_imem_addr,
   output logic [31:0] o_imem_wdata,
   output logic        o_core_resetn,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [15:0] o_word_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
   } state_t;

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t      state;
   logic [7:0]  len_lo;
   logic [7:0]  csum;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  lane;
   logic [23:0] word_buf;
   logic [15:0] rx_len;

   assign rx_len = {i_rx_data, len_lo};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= S_IDLE;
         len_lo        <= 8'h00;
         csum          <= 8'h00;
         len           <= 16'h0000;
         word_idx      <= 16'h0000;
         lane          <= 2'd0;
         word_buf      <= 24'h000000;
         o_imem_we     <= 1'b0;
         o_imem_addr   <= BASE_ADDR;
         o_imem_wdata  <= 32'h0000_0000;
         o_core_resetn <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_error       <= 1'b0;
         o_word_count  <= 16'h0000;
      end else begin
         o_imem_we <= 1'b0;
         if (i_rx_valid) begin
            case (state)
               S_IDLE, S_ERROR: begin
                  if (i_rx_data == 8'hA5) begin
                     state        <= S_LEN_LO;
                     o_error      <= 1'b0;
                     o_busy       <= 1'b1;
                     o_word_count <= 16'h0000;
                     csum         <= 8'h00;
                     lane         <= 2'd0;
                     word_idx     <= 16'h0000;
                  end
               end
               S_LEN_LO: begin
                  len_lo <= i_rx_data;
                  csum   <= csum ^ i_rx_data;
                  state  <= S_LEN_HI;
               end
               S_LEN_HI: begin
                  len  <= rx_len;
                  csum <= csum ^ i_rx_data;
                  if ({1'b0, rx_len} > MAX_LEN) begin
                     state   <= S_ERROR;
                     o_error <= 1'b1;
                     o_busy  <= 1'b0;
                  end else if (rx_len == 16'h0000) begin
                     state <= S_CSUM;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  // Little-endian: bytes shift in from the top so byte 0 ends up in [7:0].
                  csum     <= csum ^ i_rx_data;
                  lane     <= lane + 2'd1;
                  word_buf <= {i_rx_data, word_buf[23:8]};
                  if (lane == 2'd3) begin
                     o_imem_we    <= 1'b1;
                     o_imem_wdata <= {i_rx_data, word_buf};
                     o_imem_addr  <= BASE_ADDR + {14'h0000, word_idx, 2'b00};
                     o_word_count <= word_idx + 16'd1;
                     word_idx     <= word_idx + 16'd1;
                     if (word_idx == len - 16'd1)
                        state <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  o_busy <= 1'b0;
                  if (i_rx_data == csum) begin
                     state         <= S_DONE;
                     o_done        <= 1'b1;
                     o_core_resetn <= 1'b1;
                  end else begin
                     state   <= S_ERROR;
                     o_error <= 1'b1;
                  end
               end
               S_DONE: begin
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   typedef logic [31:0] word_q_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_resetn;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] word_count;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] wr_q[$];

   always #5 clk = ~clk;

   imem_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_rx_valid   (rx_valid),
      .i_rx_data    (rx_data),
      .o_imem_we    (imem_we),
      .o_imem_addr  (imem_addr),
      .o_imem_wdata (imem_wdata),
      .o_core_resetn(core_resetn),
      .o_busy       (busy),
      .o_done       (done),
      .o_error      (error),
      .o_word_count (word_count)
   );

   always @(negedge clk)
      if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      #1;
      reset = 1'b0;
      wr_q.delete();
   endtask

   // Frame built from a word list; checksum is the XOR of length and data bytes.
   task automatic send_frame(input word_q_t w, input logic [7:0] bad);
      logic [7:0]  cs;
      logic [15:0] n;
      logic [31:0] cur;
      n  = 16'(w.size());
      cs = n[7:0] ^ n[15:8];
      send_byte(8'hA5);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      foreach (w[i]) begin
         cur = w[i];
         for (int k = 0; k < 4; k++) begin
            send_byte(cur[8*k +: 8]);
            cs ^= cur[8*k +: 8];
         end
      end
      send_byte(cs ^ bad);
   endtask

   task automatic check_writes(input string tag, input word_q_t w);
      check({tag, ".nwrites"}, 32'(wr_q.size()), 32'(w.size()));
      foreach (w[i]) begin
         if (i < wr_q.size()) begin
            check({tag, ".addr"}, wr_q[i][63:32], 32'(i * 4));
            check({tag, ".data"}, wr_q[i][31:0], w[i]);
         end
      end
      wr_q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".we"},     32'(imem_we),     32'd0);
      check({tag, ".addr"},   imem_addr,        32'h0);
      check({tag, ".wdata"},  imem_wdata,       32'h0);
      check({tag, ".coren"},  32'(core_resetn), 32'd0);
      check({tag, ".busy"},   32'(busy),        32'd0);
      check({tag, ".done"},   32'(done),        32'd0);
      check({tag, ".error"},  32'(error),       32'd0);
      check({tag, ".wcount"}, 32'(word_count),  32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      @(negedge clk);
      #1;
      do_reset();
      check_reset_vals("rst");

      // Leading junk then a two-word image, all back-to-back.
      send_byte(8'hFF);
      send_byte(8'h3C);
      send_frame('{32'h0000_0013, 32'h0010_0093}, 8'h00);
      check("good.done",   32'(done),        32'd1);
      check("good.coren",  32'(core_resetn), 32'd1);
      check("good.busy",   32'(busy),        32'd0);
      check("good.wcount", 32'(word_count),  32'd2);
      check_writes("good", '{32'h0000_0013, 32'h0010_0093});
      idle(3);
      check("good.addr_hold",  imem_addr,  32'h4);
      check("good.wdata_hold", imem_wdata, 32'h0010_0093);
      send_frame('{32'hDEAD_BEEF}, 8'h00);
      check("done_ignore.done",  32'(done),        32'd1);
      check("done_ignore.busy",  32'(busy),        32'd0);
      check("done_ignore.coren", 32'(core_resetn), 32'd1);
      check_writes("done_ignore", '{});

      // Bad checksum, then a good frame straight out of ERROR.
      do_reset();
      send_frame('{32'h0000_0013, 32'h0010_0093}, 8'h01);
      check("bad.error", 32'(error),       32'd1);
      check("bad.done",  32'(done),        32'd0);
      check("bad.coren", 32'(core_resetn), 32'd0);
      check("bad.busy",  32'(busy),        32'd0);
      check_writes("bad", '{32'h0000_0013, 32'h0010_0093});
      send_byte(8'hA5);
      check("rehdr.error", 32'(error), 32'd0);
      check("rehdr.busy",  32'(busy),  32'd1);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h01 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12);
      check("recover.done",  32'(done),        32'd1);
      check("recover.error", 32'(error),       32'd0);
      check("recover.coren", 32'(core_resetn), 32'd1);
      check_writes("recover", '{32'h1234_5678});

      // Length boundary: 256 accepted, 257 rejected.
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h01);
      check("len256.busy",  32'(busy),  32'd1);
      check("len256.error", 32'(error), 32'd0);
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h01);
      check("len257.error", 32'(error),       32'd1);
      check("len257.busy",  32'(busy),        32'd0);
      check("len257.coren", 32'(core_resetn), 32'd0);
      idle(2);
      check_writes("len257", '{});

      // Empty image.
      do_reset();
      send_frame('{}, 8'h00);
      check("empty.done",   32'(done),       32'd1);
      check("empty.wcount", 32'(word_count), 32'd0);
      check_writes("empty", '{});

      // A5 inside data is data, not a restart.
      do_reset();
      send_frame('{32'hA500_A5A5, 32'h00A5_0000}, 8'h00);
      check("a5data.done",   32'(done),       32'd1);
      check("a5data.wcount", 32'(word_count), 32'd2);
      check_writes("a5data", '{32'hA500_A5A5, 32'h00A5_0000});

      // Reset after 6 bytes abandons the frame.
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check("midrst.busy_before", 32'(busy), 32'd1);
      do_reset();
      check_reset_vals("midrst");
      send_byte(8'h44);
      send_byte(8'h55);
      send_byte(8'h66);
      send_byte(8'h77);
      send_byte(8'h88);
      idle(2);
      check("midrst.busy_after", 32'(busy), 32'd0);
      check_writes("midrst", '{});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
